// File: rtl/sw_handshake_driver.sv
// sw_handshake_driver
// Board-side producer for the CPU switch-input handshake (sw8 strobe + sws bus).
// Synchronises and debounces a raw push-button and raw slide switches. Each
// accepted press captures the switches into sws, waits one setup cycle, then
// raises sw8 while sws stays frozen.
//
// Optional build macro AUTO_RELEASE_EN: sw8 drops after PULSE_CYCLES cycles
// even while the key is still held; the FSM then parks in WAIT_RELEASE until
// the debounced key goes low.

module sw_handshake_driver #(
  parameter int n            = 8,
  parameter int DB_CYCLES    = 16,
  parameter int CNT_W        = 4,
  parameter int PULSE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_raw,
  input  logic [n-1:0]     sw_raw,
  output logic             sw8,
  output logic [n-1:0]     sws,
  output logic [CNT_W-1:0] press_cnt,
  output logic             busy
);

  localparam int DB_W = $clog2(DB_CYCLES);
`ifdef AUTO_RELEASE_EN
  localparam int PW   = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_CAPTURE      = 2'd1,
    ST_ASSERT       = 2'd2
`ifdef AUTO_RELEASE_EN
    ,ST_WAIT_RELEASE = 2'd3
`endif
  } state_t;

  // Synchroniser chains
  logic           r_key_s1;
  logic           r_key_s2;
  logic [n-1:0]   r_sw_s1;
  logic [n-1:0]   r_sw_s2;

  // Debounce
  logic           r_key_db;
  logic [DB_W-1:0] r_db_cnt;

  // Handshake FSM and its registered outputs
  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sw8;
  logic             w_sw8_nxt;
  logic [n-1:0]     r_sws;
  logic [n-1:0]     w_sws_nxt;
  logic [CNT_W-1:0] r_press_cnt;
  logic [CNT_W-1:0] w_press_cnt_nxt;
`ifdef AUTO_RELEASE_EN
  logic [PW-1:0]    r_pulse_cnt;
  logic [PW-1:0]    w_pulse_cnt_nxt;
`endif

  // Two-flop synchronisers for the key and every switch bit. The switches are
  // quasi-static, so a per-bit chain is enough: the bus is only sampled long
  // after the operator has set it.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      r_key_s1 <= 1'b0;
      r_key_s2 <= 1'b0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_key_s1 <= key_raw;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= sw_raw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Debounce: accept a new key level only after DB_CYCLES consecutive
  // synchronised samples disagree with the current debounced level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_db <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_key_s2 == r_key_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DB_CYCLES - 1)) begin
      r_key_db <= r_key_s2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_sw8       <= 1'b0;
      r_sws       <= '0;
      r_press_cnt <= '0;
`ifdef AUTO_RELEASE_EN
      r_pulse_cnt <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_sw8       <= w_sw8_nxt;
      r_sws       <= w_sws_nxt;
      r_press_cnt <= w_press_cnt_nxt;
`ifdef AUTO_RELEASE_EN
      r_pulse_cnt <= w_pulse_cnt_nxt;
`endif
    end
  end

  // Next-state and next-output logic for the handshake.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt     = r_state;
    w_sw8_nxt       = r_sw8;
    w_sws_nxt       = r_sws;
    w_press_cnt_nxt = r_press_cnt;
`ifdef AUTO_RELEASE_EN
    w_pulse_cnt_nxt = r_pulse_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        w_sw8_nxt = 1'b0;
        // Every path back into IDLE requires key_db low, and a new rise needs
        // DB_CYCLES more samples, so key_db high here is always a fresh press.
        if (r_key_db) begin
          w_sws_nxt       = r_sw_s2;
          w_press_cnt_nxt = r_press_cnt + CNT_W'(1);
          w_state_nxt     = ST_CAPTURE;
        end
      end

      // One setup cycle with sws already valid and sw8 still low.
      ST_CAPTURE: begin
        w_sw8_nxt   = 1'b1;
        w_state_nxt = ST_ASSERT;
`ifdef AUTO_RELEASE_EN
        w_pulse_cnt_nxt = '0;
`endif
      end

      ST_ASSERT: begin
        if (!r_key_db) begin
          w_sw8_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
`ifdef AUTO_RELEASE_EN
        else if (r_pulse_cnt == PW'(PULSE_CYCLES - 1)) begin
          w_sw8_nxt   = 1'b0;
          w_state_nxt = ST_WAIT_RELEASE;
        end else begin
          w_pulse_cnt_nxt = r_pulse_cnt + PW'(1);
        end

      end

      // Strobe already dropped; hold off new presses until the key is released.
      ST_WAIT_RELEASE: begin
        w_sw8_nxt = 1'b0;
        if (!r_key_db) begin
          w_state_nxt = ST_IDLE;
        end
`endif
      end

      default: begin
        w_sw8_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign sw8       = r_sw8;
  assign sws       = r_sws;
  assign press_cnt = r_press_cnt;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sw_handshake_driver.sv
// Self-checking bench for sw_handshake_driver (DB_CYCLES=4, PULSE_CYCLES=3, n=8).
// The reference model works from the debounced-key timeline: it records the
// edge where the debounced level rises and falls, and derives capture, strobe
// and busy windows from those edge numbers.

module tb_sw_handshake_driver;

  localparam int N  = 8;
  localparam int DB = 4;
  localparam int CW = 4;
  localparam int PC = 3;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          key_raw = 1'b0;
  logic [N-1:0]  sw_raw = '0;
  logic          sw8;
  logic [N-1:0]  sws;
  logic [CW-1:0] press_cnt;
  logic          busy;

  int total;
  int bad;

  sw_handshake_driver #(
    .n            (N),
    .DB_CYCLES    (DB),
    .CNT_W        (CW),
    .PULSE_CYCLES (PC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_raw   (key_raw),
    .sw_raw    (sw_raw),
    .sw8       (sw8),
    .sws       (sws),
    .press_cnt (press_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int            k;        // edges since reset
  int            rise_e;   // edge at which debounced key last rose
  int            fall_e;   // first edge after rise_e at which it fell
  int            run;      // consecutive synced samples disagreeing with m_db
  logic          m_s1, m_s2, m_db;
  logic [N-1:0]  m_sw1, m_sw2;
  logic [N-1:0]  m_sws;
  logic [CW-1:0] m_cnt;
  logic          m_sw8, m_busy;

  task automatic model_reset();
    k = 0; rise_e = -100; fall_e = -100; run = 0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0;
    m_sw1 = '0; m_sw2 = '0; m_sws = '0; m_cnt = '0;
    m_sw8 = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_step();
    logic         synced;
    logic [N-1:0] sw_synced;
    int           busy_end;
    int           hi_end;
    k++;
    synced    = m_s2;
    sw_synced = m_sw2;
    m_s2 = m_s1;  m_s1 = key_raw;
    m_sw2 = m_sw1; m_sw1 = sw_raw;
    // capture happens one edge after the debounced rise
    if (rise_e == k - 1) begin
      m_sws = sw_synced;
      m_cnt = m_cnt + 4'd1;
    end
    if (synced != m_db) run++;
    else run = 0;
    if (run == DB) begin
      m_db = ~m_db;
      run = 0;
      if (m_db) begin rise_e = k; fall_e = BIG; end
      else fall_e = k;
    end
    // busy from capture until the edge the debounced key falls (at least through strobe cycle)
    busy_end = (fall_e > rise_e + 2) ? fall_e : rise_e + 2;
    hi_end   = busy_end;
`ifdef AUTO_RELEASE_EN
    if (hi_end > rise_e + PC + 1) hi_end = rise_e + PC + 1;
`endif
    m_busy = (k >= rise_e + 1) && (k <= busy_end);
    m_sw8  = (k >= rise_e + 2) && (k <= hi_end);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    total++; if (sw8 !== 1'b0) begin bad++; $display("FAIL reset_sw8: got %b want 0", sw8); end
    total++; if (sws !== 8'h00) begin bad++; $display("FAIL reset_sws: got %h want 00", sws); end
    total++; if (press_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", press_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
  endtask

  task automatic test_press();
    sw_raw = 8'h08;
    for (int c = 1; c <= 32; c++) begin
      key_raw = (c <= 20);
      @(negedge clk);
      total++;
      if ({sw8, busy, press_cnt, sws} !== {m_sw8, m_busy, m_cnt, m_sws}) begin
        bad++;
        $display("FAIL press c=%0d: dut sw8=%b busy=%b cnt=%0d sws=%h model sw8=%b busy=%b cnt=%0d sws=%h",
                 c, sw8, busy, press_cnt, sws, m_sw8, m_busy, m_cnt, m_sws);
      end
      if (c == 6) begin
        total++; if (sws !== 8'h00 || sw8 !== 1'b0) begin bad++; $display("FAIL press_e6: sws=%h sw8=%b want 00/0", sws, sw8); end
      end
      if (c == 7) begin
        total++; if (sws !== 8'h08 || sw8 !== 1'b0 || press_cnt !== 4'd1) begin
          bad++; $display("FAIL press_e7: sws=%h sw8=%b cnt=%0d want 08/0/1", sws, sw8, press_cnt);
        end
      end
      if (c == 8) begin
        total++; if (sw8 !== 1'b1) begin bad++; $display("FAIL press_e8: sw8=%b want 1", sw8); end
      end
`ifndef AUTO_RELEASE_EN
      if (c == 26) begin
        total++; if (sw8 !== 1'b1) begin bad++; $display("FAIL release_e6: sw8=%b want 1", sw8); end
      end
`endif
      if (c == 27) begin
        total++; if (sw8 !== 1'b0 || sws !== 8'h08) begin bad++; $display("FAIL release_e7: sw8=%b sws=%h want 0/08", sw8, sws); end
      end
      if (c == 32) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy: busy=%b want 0", busy); end
      end
    end
  endtask

  task automatic test_bounce();
    logic [CW-1:0] cnt0;
    logic          lvl;
    int            left;
    cnt0 = m_cnt; lvl = 1'b0; left = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c <= 30) begin
        if (left == 0) begin lvl = ~lvl; left = $urandom_range(1, 3); end
        left--;
        key_raw = lvl;
      end else begin
        key_raw = 1'b0;
      end
      @(negedge clk);
      total++;
      if ({sw8, busy, press_cnt, sws} !== {m_sw8, m_busy, m_cnt, m_sws}) begin
        bad++;
        $display("FAIL bounce c=%0d: dut sw8=%b busy=%b cnt=%0d sws=%h model sw8=%b busy=%b cnt=%0d sws=%h",
                 c, sw8, busy, press_cnt, sws, m_sw8, m_busy, m_cnt, m_sws);
      end
      total++; if (sw8 !== 1'b0) begin bad++; $display("FAIL bounce_sw8 c=%0d: sw8=%b want 0", c, sw8); end
    end
    total++; if (press_cnt !== cnt0) begin bad++; $display("FAIL bounce_cnt: got %0d want %0d", press_cnt, cnt0); end
  endtask

  task automatic test_freeze();
    logic [CW-1:0] cnt0;
    cnt0 = m_cnt;
    for (int c = 1; c <= 56; c++) begin
      key_raw = (c <= 20) || (c >= 33 && c <= 44);
      sw_raw  = (c <= 10) ? 8'h08 : 8'h04;
      @(negedge clk);
      total++;
      if ({sw8, busy, press_cnt, sws} !== {m_sw8, m_busy, m_cnt, m_sws}) begin
        bad++;
        $display("FAIL freeze c=%0d: dut sw8=%b busy=%b cnt=%0d sws=%h model sw8=%b busy=%b cnt=%0d sws=%h",
                 c, sw8, busy, press_cnt, sws, m_sw8, m_busy, m_cnt, m_sws);
      end
      if (c == 20) begin
        total++; if (sws !== 8'h08) begin bad++; $display("FAIL freeze_hold: sws=%h want 08", sws); end
`ifndef AUTO_RELEASE_EN
        total++; if (sw8 !== 1'b1) begin bad++; $display("FAIL freeze_sw8: sw8=%b want 1", sw8); end
`endif
      end
      if (c == 38) begin
        total++; if (sws !== 8'h08) begin bad++; $display("FAIL freeze_keep: sws=%h want 08", sws); end
      end
      if (c == 39) begin
        total++; if (sws !== 8'h04 || press_cnt !== cnt0 + 4'd2) begin
          bad++; $display("FAIL freeze_next: sws=%h cnt=%0d want 04/%0d", sws, press_cnt, cnt0 + 4'd2);
        end
      end
      if (c == 56) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL freeze_idle: busy=%b want 0", busy); end
      end
    end
  endtask

  task automatic test_wrap();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int p = 0; p < 16; p++) begin
      for (int c = 1; c <= 24; c++) begin
        key_raw = (c <= 10);
        if (c == 1) sw_raw = 8'($urandom);
        @(negedge clk);
        total++;
        if ({sw8, busy, press_cnt, sws} !== {m_sw8, m_busy, m_cnt, m_sws}) begin
          bad++;
          $display("FAIL wrap p=%0d c=%0d: dut sw8=%b busy=%b cnt=%0d sws=%h model sw8=%b busy=%b cnt=%0d sws=%h",
                   p, c, sw8, busy, press_cnt, sws, m_sw8, m_busy, m_cnt, m_sws);
        end
        if (c == 6) begin
          total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_busy_pre p=%0d: busy=%b want 0", p, busy); end
        end
        if (c == 7) begin
          total++; if (busy !== 1'b1 || press_cnt !== 4'(p + 1)) begin
            bad++; $display("FAIL wrap_cap p=%0d: busy=%b cnt=%0d want 1/%0d", p, busy, press_cnt, 4'(p + 1));
          end
        end
        if (c == 16) begin
          total++; if (busy !== 1'b1) begin bad++; $display("FAIL wrap_busy_hold p=%0d: busy=%b want 1", p, busy); end
        end
        if (c == 17) begin
          total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_busy_end p=%0d: busy=%b want 0", p, busy); end
        end
      end
    end
    total++; if (press_cnt !== 4'd0) begin bad++; $display("FAIL wrap_cnt: got %0d want 0", press_cnt); end
  endtask

  task automatic test_random();
    logic lvl;
    int   left;
    lvl = 1'b0; left = 0;
    for (int c = 1; c <= 400; c++) begin
      if (c <= 380) begin
        if (left == 0) begin lvl = ~lvl; left = $urandom_range(1, 10); end
        left--;
        key_raw = lvl;
      end else begin
        key_raw = 1'b0;
      end
      sw_raw = 8'($urandom);
      @(negedge clk);
      total++;
      if ({sw8, busy, press_cnt, sws} !== {m_sw8, m_busy, m_cnt, m_sws}) begin
        bad++;
        $display("FAIL random c=%0d: dut sw8=%b busy=%b cnt=%0d sws=%h model sw8=%b busy=%b cnt=%0d sws=%h",
                 c, sw8, busy, press_cnt, sws, m_sw8, m_busy, m_cnt, m_sws);
      end
    end
  endtask

`ifdef AUTO_RELEASE_EN
  task automatic test_auto_release();
    logic [CW-1:0] cnt0;
    int            high;
    cnt0 = m_cnt; high = 0;
    sw_raw = 8'hA5;
    for (int c = 1; c <= 50; c++) begin
      key_raw = (c <= 30);
      @(negedge clk);
      if (sw8 === 1'b1) high++;
      total++;
      if ({sw8, busy, press_cnt, sws} !== {m_sw8, m_busy, m_cnt, m_sws}) begin
        bad++;
        $display("FAIL auto c=%0d: dut sw8=%b busy=%b cnt=%0d sws=%h model sw8=%b busy=%b cnt=%0d sws=%h",
                 c, sw8, busy, press_cnt, sws, m_sw8, m_busy, m_cnt, m_sws);
      end
      if (c == 30 || c == 36) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL auto_busy c=%0d: busy=%b want 1", c, busy); end
      end
      if (c == 37) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL auto_idle: busy=%b want 0", busy); end
      end
    end
    total++; if (high != PC) begin bad++; $display("FAIL auto_pulse: high=%0d want %0d", high, PC); end
    total++; if (press_cnt !== cnt0 + 4'd1) begin bad++; $display("FAIL auto_cnt: got %0d want %0d", press_cnt, cnt0 + 4'd1); end
  endtask
`endif

  task automatic test_async_reset();
    sw_raw = 8'h5A;
    for (int c = 1; c <= 9; c++) begin
      key_raw = 1'b1;
      @(negedge clk);
      total++;
      if ({sw8, busy, press_cnt, sws} !== {m_sw8, m_busy, m_cnt, m_sws}) begin
        bad++;
        $display("FAIL arst_pre c=%0d: dut sw8=%b busy=%b cnt=%0d sws=%h model sw8=%b busy=%b cnt=%0d sws=%h",
                 c, sw8, busy, press_cnt, sws, m_sw8, m_busy, m_cnt, m_sws);
      end
    end
    total++; if (sw8 !== 1'b1) begin bad++; $display("FAIL arst_assert: sw8=%b want 1", sw8); end
    #2 reset = 1'b0;
    #1;
    total++; if (sw8 !== 1'b0) begin bad++; $display("FAIL arst_sw8: got %b want 0", sw8); end
    total++; if (sws !== 8'h00) begin bad++; $display("FAIL arst_sws: got %h want 00", sws); end
    total++; if (press_cnt !== 4'd0) begin bad++; $display("FAIL arst_cnt: got %0d want 0", press_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
    @(negedge clk);
    reset  = 1'b1;
    sw_raw = 8'hC3;
    for (int c = 1; c <= 26; c++) begin
      key_raw = (c <= 12);
      @(negedge clk);
      total++;
      if ({sw8, busy, press_cnt, sws} !== {m_sw8, m_busy, m_cnt, m_sws}) begin
        bad++;
        $display("FAIL arst_post c=%0d: dut sw8=%b busy=%b cnt=%0d sws=%h model sw8=%b busy=%b cnt=%0d sws=%h",
                 c, sw8, busy, press_cnt, sws, m_sw8, m_busy, m_cnt, m_sws);
      end
      if (c == 7) begin
        total++; if (sws !== 8'hC3 || press_cnt !== 4'd1 || sw8 !== 1'b0) begin
          bad++; $display("FAIL arst_cap: sws=%h cnt=%0d sw8=%b want C3/1/0", sws, press_cnt, sw8);
        end
      end
      if (c == 8) begin
        total++; if (sw8 !== 1'b1) begin bad++; $display("FAIL arst_sw8_rise: sw8=%b want 1", sw8); end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_press();
    test_bounce();
    test_freeze();
    test_wrap();
    test_random();
`ifdef AUTO_RELEASE_EN
    test_auto_release();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
